// File: rtl/disp_lane_queue.sv
// Dispatch queue between rename/dispatch and one execution block.
// Accepts micro-op groups, presents oldest entries on in-order lanes.
module disp_lane_queue #(
  parameter int IN_WID  = 4,
  parameter int OUT_WID = 2,
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [IN_WID-1:0]         in_vld,
  input  logic [IN_WID*DATA_W-1:0]  in_data,
  output logic                      in_rdy,
  output logic [OUT_WID-1:0]        out_req,
  input  logic [OUT_WID-1:0]        out_rdy,
  output logic [OUT_WID*DATA_W-1:0] out_data,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     n_in, n_out;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              enq;
  logic              stop;

  assign count  = count_q;
  assign in_rdy = (CW'(DEPTH) - count_q) >= CW'(IN_WID);
  assign enq    = in_rdy & (|in_vld) & ~flush;

  for (genvar i = 0; i < OUT_WID; i++) begin : g_lane
    assign out_req[i] = count_q > CW'(i);
    assign out_data[i*DATA_W +: DATA_W] = mem_q[head_q + PW'(i)];
  end

  always_comb begin
    n_in = '0;
    for (int i = 0; i < IN_WID; i++) begin
      n_in = n_in + CW'(in_vld[i]);
    end
  end

  // Retire only the unbroken run of handshakes starting at lane 0.
  always_comb begin
    n_out = '0;
    stop  = 1'b0;
    for (int i = 0; i < OUT_WID; i++) begin
      if (!stop && out_req[i] && out_rdy[i]) begin
        n_out = n_out + CW'(1);
      end else begin
        stop = 1'b1;
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < IN_WID; i++) begin
      if (enq && in_vld[i]) begin
        mem_d[tail_q + PW'(i)] = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d = PW'(head_q + n_out);
      if (enq) begin
        tail_d  = PW'(tail_q + n_in);
        count_d = count_q + n_in - n_out;
      end else begin
        count_d = count_q - n_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

`ifndef SYNTHESIS
  a_prefix: assert property (@(posedge clk) disable iff (!rst)
    (in_vld & (in_vld + IN_WID'(1))) == '0);
  a_count: assert property (@(posedge clk) disable iff (!rst)
    count_q <= CW'(DEPTH));
  a_enq: assert property (@(posedge clk) disable iff (!rst)
    enq |-> in_rdy);
  a_hold: assert property (@(posedge clk) disable iff (!rst)
    ((|in_vld) && !in_rdy && !flush) |=> $stable(in_data));
`endif
endmodule
